// File: rtl/video_sync_decoder.sv
// Sync receiver: rebuilds pixel x/y from hsync/vsync, measures line/frame totals,
// and tracks timing lock plus 50/60 Hz detection.
module video_sync_decoder #(
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned W        = 10,
  parameter int unsigned H_MAX    = 1023,
  parameter int unsigned V_MAX    = 1023,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned FD_SPLIT = 287
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hsync,
  input  logic         vsync,
  output logic [W-1:0] video_x,
  output logic [W-1:0] video_y,
  output logic         line_start,
  output logic         frame_start,
  output logic [W-1:0] h_total,
  output logic [W-1:0] v_total,
  output logic         locked,
  output logic         fd
);

  localparam int unsigned CW = $clog2(LOCK_CNT + 2);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  logic         hs_prev_q, vs_prev_q, vs_pend_q, vs_pend_d;
  logic [W-1:0] x_q, x_d, y_q, y_d, ht_q, ht_d, vt_q, vt_d;
  logic         ls_q, ls_d, fs_q, fs_d;
  state_e       state_q;
  logic [CW-1:0] match_cnt_q;
  logic [W-1:0] st_h_q, st_v_q;
  logic         locked_q, fd_q;

  logic hs_act, vs_act, hs_edge, vs_edge, frame_fire;
  logic timeout, frame_match, fd_hit;

  assign hs_act     = (hsync == HS_POL);
  assign vs_act     = (vsync == VS_POL);
  assign hs_edge    = hs_act & ~hs_prev_q;
  assign vs_edge    = vs_act & ~vs_prev_q;
  assign frame_fire = hs_edge & (vs_pend_q | vs_edge);

  // Position counters and line/frame measurement
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    ht_d      = ht_q;
    vt_d      = vt_q;
    ls_d      = 1'b0;
    fs_d      = 1'b0;
    vs_pend_d = vs_pend_q | vs_edge;
    if (hs_edge) begin
      x_d  = '0;
      ht_d = x_q + W'(1);
      ls_d = 1'b1;
      if (frame_fire) begin
        y_d       = '0;
        vt_d      = y_q + W'(1);
        fs_d      = 1'b1;
        vs_pend_d = 1'b0;
      end else if (y_q != W'(V_MAX)) begin
        y_d = y_q + W'(1);
      end
    end else if (x_q != W'(H_MAX)) begin
      x_d = x_q + W'(1);
    end
  end

  // Edge history presets to the asserted level so a sync held through reset is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      vs_pend_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      ht_q      <= '0;
      vt_q      <= '0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      hs_prev_q <= hs_act;
      vs_prev_q <= vs_act;
      vs_pend_q <= vs_pend_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ht_q      <= ht_d;
      vt_q      <= vt_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
    end
  end

  assign timeout     = (x_q == W'(H_MAX)) || (y_q == W'(V_MAX));
  assign frame_match = (ht_q == st_h_q) && (vt_q == st_v_q);
  assign fd_hit      = (vt_q <= W'(FD_SPLIT));

  // Lock tracker: judges the freshly registered totals against those from the previous frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_UNLOCKED;
      match_cnt_q <= '0;
      st_h_q      <= '0;
      st_v_q      <= '0;
      locked_q    <= 1'b0;
      fd_q        <= 1'b0;
    end else if (timeout) begin
      state_q     <= ST_UNLOCKED;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      fd_q        <= 1'b0;
    end else if (fs_q) begin
      st_h_q <= ht_q;
      st_v_q <= vt_q;
      case (state_q)
        ST_UNLOCKED: begin
          state_q     <= ST_ACQUIRE;
          match_cnt_q <= '0;
        end
        ST_ACQUIRE: begin
          if (frame_match) begin
            match_cnt_q <= match_cnt_q + CW'(1);
            if ((match_cnt_q + CW'(1)) == CW'(LOCK_CNT)) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              fd_q     <= fd_hit;
            end
          end else begin
            match_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (frame_match) begin
            fd_q <= fd_hit;
          end else begin
            state_q     <= ST_ACQUIRE;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            fd_q        <= 1'b0;
          end
        end
        default: state_q <= ST_UNLOCKED;
      endcase
    end else if (ls_q && (state_q == ST_LOCKED) && (ht_q != st_h_q)) begin
      state_q     <= ST_ACQUIRE;
      match_cnt_q <= '0;
      st_h_q      <= ht_q;
      locked_q    <= 1'b0;
      fd_q        <= 1'b0;
    end
  end

  assign video_x     = x_q;
  assign video_y     = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign h_total     = ht_q;
  assign v_total     = vt_q;
  assign locked      = locked_q;
  assign fd          = fd_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Bench for video_sync_decoder: line-start scoreboard fed by a stimulus model,
// plus per-scenario lock, timeout and reset checks.
module tb_video_sync_decoder;

  logic       clk, reset, hsync, vsync;
  logic [9:0] video_x, video_y, h_total, v_total;
  logic       line_start, frame_start, locked, fd;

  int tests_run = 0;
  int fails     = 0;

  typedef struct {
    logic       frame;
    logic [9:0] y;
    logic       h_known;
    logic [9:0] ht;
    logic [9:0] vt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int   m_y, m_prev_len;
  logic m_pend, m_hknown;

  video_sync_decoder dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .video_x(video_x), .video_y(video_y),
    .line_start(line_start), .frame_start(frame_start),
    .h_total(h_total), .v_total(v_total),
    .locked(locked), .fd(fd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every line_start must match the next expectation pushed by drive_line
  always @(negedge clk) begin
    if (!reset && line_start) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_line_start y=%0d x=%0d", video_y, video_x);
      end else begin
        mon_e = sb_q.pop_front();
        if ({frame_start, video_y, video_x} !== {mon_e.frame, mon_e.y, 10'd0}) begin
          fails++;
          $display("FAIL sb_position got fs=%0d y=%0d x=%0d expected fs=%0d y=%0d x=0",
                   frame_start, video_y, video_x, mon_e.frame, mon_e.y);
        end
        if (mon_e.h_known) begin
          tests_run++;
          if (h_total !== mon_e.ht) begin
            fails++;
            $display("FAIL sb_h_total got %0d expected %0d", h_total, mon_e.ht);
          end
        end
        if (mon_e.frame) begin
          tests_run++;
          if (v_total !== mon_e.vt) begin
            fails++;
            $display("FAIL sb_v_total got %0d expected %0d", v_total, mon_e.vt);
          end
        end
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    m_y = 0; m_prev_len = 0; m_pend = 1'b0; m_hknown = 1'b0;
  endtask

  // mode 0: plain line, 1: vsync active whole line (edges coincide), 2: vsync rises mid-line
  task automatic drive_line(input int len, input int mode);
    exp_t e;
    e.frame   = (mode == 1) || m_pend;
    e.h_known = m_hknown;
    e.ht      = 10'(m_prev_len);
    e.vt      = 10'(m_y + 1);
    if (e.frame) begin
      m_y = 0; m_pend = 1'b0;
    end else if (m_y != 1023) begin
      m_y = m_y + 1;
    end
    e.y = 10'(m_y);
    sb_q.push_back(e);
    m_prev_len = len; m_hknown = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      hsync = (i < 2);
      vsync = (mode == 1) || ((mode == 2) && (i >= len / 2));
    end
    if (mode == 2) m_pend = 1'b1;
  endtask

  task automatic drive_frame(input int nlines, input int len);
    drive_line(len, 1);
    for (int i = 1; i < nlines; i++) drive_line(len, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({video_x, video_y, h_total, v_total, line_start, frame_start, locked, fd} !== 44'd0) begin
      fails++;
      $display("FAIL reset_outputs got x=%0d y=%0d ht=%0d vt=%0d ls=%0d fs=%0d lk=%0d fd=%0d expected all 0",
               video_x, video_y, h_total, v_total, line_start, frame_start, locked, fd);
    end
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ntsc_lock();
    repeat (3) drive_frame(262, 12);
    @(negedge clk);
    tests_run++;
    if (locked !== 1'b0) begin
      fails++; $display("FAIL ntsc_early_lock got %0d expected 0", locked);
    end
    drive_frame(262, 12);
    @(negedge clk);
    tests_run++;
    if ({locked, fd, h_total, v_total} !== {1'b1, 1'b1, 10'd12, 10'd262}) begin
      fails++;
      $display("FAIL ntsc_lock got lk=%0d fd=%0d ht=%0d vt=%0d expected lk=1 fd=1 ht=12 vt=262",
               locked, fd, h_total, v_total);
    end
  endtask

  task automatic test_pal_switch();
    drive_frame(312, 12);
    @(negedge clk);
    tests_run++;
    if (locked !== 1'b1) begin
      fails++; $display("FAIL pal_hold_lock got %0d expected 1", locked);
    end
    drive_line(12, 1);
    @(negedge clk);
    tests_run++;
    if (locked !== 1'b0) begin
      fails++; $display("FAIL pal_unlock got %0d expected 0", locked);
    end
    for (int i = 1; i < 312; i++) drive_line(12, 0);
    drive_frame(312, 12);
    drive_line(12, 1);
    @(negedge clk);
    tests_run++;
    if ({locked, fd, v_total} !== {1'b1, 1'b0, 10'd312}) begin
      fails++;
      $display("FAIL pal_relock got lk=%0d fd=%0d vt=%0d expected lk=1 fd=0 vt=312", locked, fd, v_total);
    end
  endtask

  task automatic test_hsync_stall();
    for (int i = 1; i < 5; i++) drive_line(12, 0);
    hsync = 1'b0;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({video_x, locked} !== {10'd1023, 1'b0}) begin
      fails++;
      $display("FAIL stall_timeout got x=%0d lk=%0d expected x=1023 lk=0", video_x, locked);
    end
    m_hknown = 1'b0;
    for (int i = 5; i < 312; i++) drive_line(12, 0);
    repeat (3) drive_frame(262, 12);
    @(negedge clk);
    tests_run++;
    if (locked !== 1'b0) begin
      fails++; $display("FAIL stall_early_lock got %0d expected 0", locked);
    end
    drive_line(12, 1);
    @(negedge clk);
    tests_run++;
    if ({locked, fd, v_total} !== {1'b1, 1'b1, 10'd262}) begin
      fails++;
      $display("FAIL stall_relock got lk=%0d fd=%0d vt=%0d expected lk=1 fd=1 vt=262", locked, fd, v_total);
    end
  endtask

  task automatic test_long_line();
    logic found;
    repeat (3) drive_line(12, 0);
    drive_line(13, 0);
    found = 1'b0;
    fork
      drive_line(12, 0);
      begin
        for (int n = 0; n < 8 && !found; n++) begin
          @(negedge clk); found = line_start;
        end
        tests_run++;
        if (!found) begin
          fails++; $display("FAIL long_line_pulse got none expected line_start");
        end else begin
          tests_run++;
          if ({h_total, locked} !== {10'd13, 1'b1}) begin
            fails++;
            $display("FAIL long_line_measure got ht=%0d lk=%0d expected ht=13 lk=1", h_total, locked);
          end
          @(negedge clk);
          tests_run++;
          if (locked !== 1'b0) begin
            fails++; $display("FAIL long_line_unlock got %0d expected 0", locked);
          end
        end
      end
    join
  endtask

  task automatic test_coincident();
    logic found;
    repeat (2) drive_line(12, 0);
    found = 1'b0;
    fork
      drive_line(12, 1);
      begin
        for (int n = 0; n < 8 && !found; n++) begin
          @(negedge clk); found = line_start;
        end
        tests_run++;
        if (!found || frame_start !== 1'b1 || video_y !== 10'd0) begin
          fails++;
          $display("FAIL coincident_start got ls=%0d fs=%0d y=%0d expected ls=1 fs=1 y=0",
                   found, frame_start, video_y);
        end
        @(negedge clk);
        tests_run++;
        if ({line_start, frame_start} !== 2'b00) begin
          fails++;
          $display("FAIL coincident_single got ls=%0d fs=%0d expected 0 0", line_start, frame_start);
        end
      end
    join
  endtask

  task automatic test_vsync_pending();
    logic found;
    drive_line(12, 0);
    drive_line(12, 2);
    found = 1'b0;
    fork
      drive_line(12, 0);
      begin
        for (int n = 0; n < 8 && !found; n++) begin
          @(negedge clk); found = line_start;
        end
        tests_run++;
        if (!found || frame_start !== 1'b1) begin
          fails++;
          $display("FAIL pending_frame got ls=%0d fs=%0d expected 1 1", found, frame_start);
        end
      end
    join
    drive_line(12, 0);
  endtask

  task automatic test_reset_behaviour();
    logic seen;
    repeat (3) drive_line(12, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    hsync = 1'b1;
    #1;
    tests_run++;
    if ({video_x, video_y, h_total, v_total, line_start, frame_start, locked, fd} !== 44'd0) begin
      fails++;
      $display("FAIL midframe_reset got x=%0d y=%0d ht=%0d vt=%0d ls=%0d fs=%0d lk=%0d fd=%0d expected all 0",
               video_x, video_y, h_total, v_total, line_start, frame_start, locked, fd);
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk); seen = seen | line_start;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL held_hsync_edge got line_start=1 expected 0");
    end
    @(posedge clk); #1; hsync = 1'b0;
    repeat (3) @(posedge clk);
    drive_line(12, 1);
    drive_line(12, 0);
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; hsync = 1'b0; vsync = 1'b0;
    model_reset();
    test_reset();
    test_ntsc_lock();
    test_pal_switch();
    test_hsync_stall();
    test_long_line();
    test_coincident();
    test_vsync_pending();
    test_reset_behaviour();
    repeat (4) @(negedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
